// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the load/store stage: FSM state encoding,
// the full-word byte-enable constant and a byte-lane extraction function.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] BE_WORD = 4'hF;

  // Pick byte lane 'lane' out of a 32-bit word.
  function automatic logic [7:0] lane_select(input logic [31:0] word,
                                             input logic [1:0]  lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/byte_lane_align.sv
// Combinational byte-lane steering for the load/store stage.
// Write side: byte-enable decode and byte replication for stores.
// Read side: byte extraction with zero extension for byte loads.
module byte_lane_align
  import mem_stage_pkg::*;
(
  input  logic        wr_byte,
  input  logic [1:0]  wr_lane,
  input  logic [31:0] wr_data_in,
  output logic [3:0]  wr_be,
  output logic [31:0] wr_data_out,
  input  logic        rd_byte,
  input  logic [1:0]  rd_lane,
  input  logic [31:0] rd_data_in,
  output logic [31:0] rd_data_out
);

  // Store steering: a byte store enables one lane and replicates the byte to all lanes.
  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    wr_be       = BE_WORD;
    wr_data_out = wr_data_in;
    if (wr_byte) begin
      wr_be       = 4'b0001 << wr_lane;
      wr_data_out = {4{wr_data_in[7:0]}};
    end
  end

  // Load steering: a byte load returns the addressed lane, zero-extended.
  always_comb begin
    rd_data_out = rd_data_in;
    if (rd_byte) begin
      rd_data_out = {24'h0, lane_select(rd_data_in, rd_lane)};
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// Load/store stage between execute and write-back. Drives a synchronous
// single-port data RAM, holds off upstream while a load is in flight and
// returns load data with its destination register as a one-cycle strobe.
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned word accesses
// (no RAM access, one-cycle fault pulse, sticky fault_addr). Without it,
// word accesses are aligned down and fault/fault_addr are tied to 0.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W     = 11,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_load,
  input  logic              req_byte,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_rd,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_en,
  output logic              ram_we,
  output logic [3:0]        ram_be,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [31:0]       ram_data2,
  output logic [3:0]        wb_addr,
  output logic              wb_en,
  output logic              stall,
  output logic              fault,
  output logic [31:0]       fault_addr
);

  localparam int CNT_W = 2;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       rd_q;
  logic             byte_q;
  logic [1:0]       lane_q;
  logic             accept;
  logic             misalign;
  logic             issue;
  logic             resp_capture;
  logic [3:0]       st_be;
  logic [31:0]      st_wdata;
  logic [31:0]      ld_data;

  // Address bits above the RAM window wrap and are intentionally dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

`ifdef MISALIGN_TRAP_EN
  assign misalign = ~req_byte & (req_addr[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign req_ready    = (state_q == IDLE) | (state_q == RESP);
  assign accept       = req_valid & req_ready;
  assign issue        = accept & ~misalign;
  assign stall        = req_valid & ~req_ready;
  assign wb_en        = (state_q == RESP);
  // Read data is valid in the last WAIT cycle; it is registered into RESP.
  assign resp_capture = (state_q == WAIT) && (cnt_q == '0);

  byte_lane_align u_align (
    .wr_byte     (req_byte),
    .wr_lane     (req_addr[1:0]),
    .wr_data_in  (req_wdata),
    .wr_be       (st_be),
    .wr_data_out (st_wdata),
    .rd_byte     (byte_q),
    .rd_lane     (lane_q),
    .rd_data_in  (ram_rdata),
    .rd_data_out (ld_data)
  );

  // State and latency counter register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic and RAM strobes; RAM outputs follow the request in its accept cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_be    = 4'b0000;
    ram_wdata = 32'h0;
    ram_addr  = '0;
    case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (issue) begin
          ram_en   = 1'b1;
          ram_addr = req_addr[ADDR_W+1:2];
          if (req_load) begin
            ram_be  = BE_WORD;
            state_d = WAIT;
            cnt_d   = CNT_W'(RD_LATENCY - 1);
          end else begin
            ram_we    = 1'b1;
            ram_be    = st_be;
            ram_wdata = st_wdata;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Remember how to steer the response of the load just issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q   <= '0;
      byte_q <= 1'b0;
      lane_q <= '0;
    end else if (issue && req_load) begin
      rd_q   <= req_rd;
      byte_q <= req_byte;
      lane_q <= req_addr[1:0];
    end
  end

  // Load result and destination register, held until the next load response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_data2 <= 32'h0;
      wb_addr   <= '0;
    end else if (resp_capture) begin
      ram_data2 <= ld_data;
      wb_addr   <= rd_q;
    end
  end

`ifdef MISALIGN_TRAP_EN
  // Fault pulse the cycle after a misaligned word request; address is sticky.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault      <= 1'b0;
      fault_addr <= 32'h0;
    end else begin
      fault <= accept & misalign;
      if (accept && misalign) begin
        fault_addr <= req_addr;
      end
    end
  end
`else
  assign fault      = 1'b0;
  assign fault_addr = 32'h0;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: a latency-accurate RAM model,
// a shadow memory built from the stimulus, and a scoreboard queue of
// expected load responses compared when wb_en fires.
module tb_mem_access_stage;

  localparam int ADDR_W = 11;
  localparam int RD_LAT = 1;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_load;
  logic              req_byte;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic [3:0]        req_rd;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_en;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  logic [31:0]       ram_data2;
  logic [3:0]        wb_addr;
  logic              wb_en;
  logic              stall;
  logic              fault;
  logic [31:0]       fault_addr;

  mem_access_stage #(.ADDR_W(ADDR_W), .RD_LATENCY(RD_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_load   (req_load),
    .req_byte   (req_byte),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_rd     (req_rd),
    .ram_addr   (ram_addr),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_be     (ram_be),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .ram_data2  (ram_data2),
    .wb_addr    (wb_addr),
    .wb_en      (wb_en),
    .stall      (stall),
    .fault      (fault),
    .fault_addr (fault_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int wb_seen  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%08h expected=0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // RAM model and shadow copy derived purely from the stimulus.
  logic [31:0] mem    [DEPTH];
  logic [31:0] shadow [DEPTH];
  logic [31:0] pipe   [RD_LAT];
  logic [31:0] wr_merge;

  function automatic logic [31:0] init_word(input int i);
    return {16'hC0DE, i[15:0]};
  endfunction

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]    = init_word(i);
      shadow[i] = init_word(i);
    end
  end

  always @(posedge clk) begin
    if (ram_en && ram_we) begin
      wr_merge = mem[ram_addr];
      for (int b = 0; b < 4; b++) begin
        if (ram_be[b]) wr_merge[8*b +: 8] = ram_wdata[8*b +: 8];
      end
      mem[ram_addr] <= wr_merge;
    end
    pipe[0] <= (ram_en && !ram_we) ? mem[ram_addr] : 32'hBAD0_BAD0;
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign ram_rdata = pipe[RD_LAT-1];

  typedef struct {
    logic [31:0] data;
    logic [3:0]  rd;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  // Scoreboard: every write-back strobe must match the oldest expected load.
  always @(negedge clk) begin
    if (!rst && wb_en) begin
      wb_seen++;
      if (sb.size() == 0) begin
        check("wb_unexpected", {31'b0, wb_en}, 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wb_data",    ram_data2, e.data);
        check("wb_addr",    {28'h0, wb_addr}, {28'h0, e.rd});
        check("wb_latency", cyc, e.cyc);
      end
    end
  end

  // Present one request, wait (bounded) for acceptance, check the RAM strobes
  // in the accept cycle and record what the response must look like.
  task automatic do_req(input logic ld, input logic by, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] rd,
                        input logic expect_wb, output int acc_cyc);
    int          waited;
    logic        mis;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    logic [31:0] w;
    int          idx;
    waited = 0;
    acc_cyc = -1;
    @(negedge clk);
    req_valid = 1'b1;
    req_load  = ld;
    req_byte  = by;
    req_addr  = addr;
    req_wdata = wd;
    req_rd    = rd;
    #1;
    while (!req_ready && waited < 20) begin
      check("stall_while_busy", {31'b0, stall}, 32'h1);
      @(negedge clk);
      #1;
      waited++;
    end
    if (!req_ready) begin
      check("ready_timeout", {31'b0, req_ready}, 32'h1);
      return;
    end
`ifdef MISALIGN_TRAP_EN
    mis = !by && (addr[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    e_be = by ? (4'b0001 << addr[1:0]) : 4'hF;
    e_wd = by ? {4{wd[7:0]}} : wd;
    idx  = int'(addr[ADDR_W+1:2]);
    check("stall_on_accept", {31'b0, stall}, 32'h0);
    check("ram_en", {31'b0, ram_en}, {31'b0, !mis});
    if (!mis) begin
      check("ram_addr", {21'h0, ram_addr}, {21'h0, addr[ADDR_W+1:2]});
      check("ram_we",   {31'b0, ram_we}, {31'b0, !ld});
      check("ram_be",   {28'h0, ram_be}, ld ? 32'hF : {28'h0, e_be});
      if (!ld) begin
        check("ram_wdata", ram_wdata, e_wd);
        for (int b = 0; b < 4; b++) begin
          if (e_be[b]) shadow[idx][8*b +: 8] = e_wd[8*b +: 8];
        end
      end else if (expect_wb) begin
        exp_t e;
        w = shadow[idx];
        e.data = by ? {24'h0, w[8*addr[1:0] +: 8]} : w;
        e.rd   = rd;
        e.cyc  = cyc + RD_LAT + 1;
        sb.push_back(e);
      end
    end
    acc_cyc = cyc;
    @(posedge clk);
  endtask

  task automatic go_idle();
    @(negedge clk);
    req_valid = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int acc;
    int prev;
    int seen0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_load  = 1'b0;
    req_byte  = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    req_rd    = 4'h0;

    // Reset values.
    @(negedge clk);
    #1;
    check("rst_req_ready",  {31'b0, req_ready}, 32'h1);
    check("rst_ram_en",     {31'b0, ram_en}, 32'h0);
    check("rst_ram_we",     {31'b0, ram_we}, 32'h0);
    check("rst_ram_be",     {28'h0, ram_be}, 32'h0);
    check("rst_wb_en",      {31'b0, wb_en}, 32'h0);
    check("rst_wb_addr",    {28'h0, wb_addr}, 32'h0);
    check("rst_ram_data2",  ram_data2, 32'h0);
    check("rst_stall",      {31'b0, stall}, 32'h0);
    check("rst_fault",      {31'b0, fault}, 32'h0);
    check("rst_fault_addr", fault_addr, 32'h0);
    rst = 1'b0;

    // Store word, then a word load with a visible WAIT cycle.
    do_req(1'b0, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 4'h0, 1'b0, acc);
    do_req(1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h3, 1'b1, acc);
    go_idle();
    check("wait_req_ready", {31'b0, req_ready}, 32'h0);
    check("wait_ram_en",    {31'b0, ram_en}, 32'h0);
    repeat (3) @(negedge clk);

    // Byte store into lane 3, reload the merged word.
    do_req(1'b0, 1'b1, 32'h0000_0013, 32'h0000_00A5, 4'h0, 1'b0, acc);
    do_req(1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h4, 1'b1, acc);

    // Byte load from lane 2 of 0x11223344.
    do_req(1'b0, 1'b0, 32'h0000_0010, 32'h1122_3344, 4'h0, 1'b0, acc);
    do_req(1'b1, 1'b1, 32'h0000_0012, 32'h0, 4'h5, 1'b1, acc);

    // Every lane: byte stores, then byte loads and a word load.
    for (int l = 0; l < 4; l++) begin
      do_req(1'b0, 1'b1, 32'h0000_0040 + l, 32'h0000_0050 + 32'(l * 17), 4'h0, 1'b0, acc);
    end
    for (int l = 0; l < 4; l++) begin
      do_req(1'b1, 1'b1, 32'h0000_0040 + l, 32'h0, 4'(l + 8), 1'b1, acc);
    end
    do_req(1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'hC, 1'b1, acc);

    // Back-to-back loads held valid, including wrap and top-of-RAM addresses.
    go_idle();
    do_req(1'b1, 1'b0, 32'h0000_2010, 32'h0, 4'h1, 1'b1, prev);
    do_req(1'b1, 1'b0, 32'h0000_1FFC, 32'h0, 4'h2, 1'b1, acc);
    check("b2b_spacing_0", acc - prev, RD_LAT + 1);
    prev = acc;
    do_req(1'b1, 1'b1, 32'hFFFF_E041, 32'h0, 4'h6, 1'b1, acc);
    check("b2b_spacing_1", acc - prev, RD_LAT + 1);
    prev = acc;
    do_req(1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'hF, 1'b1, acc);
    check("b2b_spacing_2", acc - prev, RD_LAT + 1);
    go_idle();
    repeat (4) @(negedge clk);

    // Reset while a load waits: no write-back may follow.
    do_req(1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'h7, 1'b0, acc);
    go_idle();
    seen0 = wb_seen;
    rst = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_mid_load_no_wb", wb_seen - seen0, 32'h0);
    check("rst_mid_load_data2", ram_data2, 32'h0);
    check("rst_mid_load_ready", {31'b0, req_ready}, 32'h1);

`ifdef MISALIGN_TRAP_EN
    // Misaligned word load traps: no RAM access, fault pulse, sticky address.
    seen0 = wb_seen;
    do_req(1'b1, 1'b0, 32'h0000_0021, 32'h0, 4'h9, 1'b0, acc);
    go_idle();
    check("fault_pulse",      {31'b0, fault}, 32'h1);
    check("fault_addr",       fault_addr, 32'h0000_0021);
    @(negedge clk);
    #1;
    check("fault_one_cycle",  {31'b0, fault}, 32'h0);
    check("fault_addr_stick", fault_addr, 32'h0000_0021);
    repeat (3) @(negedge clk);
    check("fault_no_wb",      wb_seen - seen0, 32'h0);
`else
    // Misaligned word store is aligned down; fault outputs stay 0.
    do_req(1'b0, 1'b0, 32'h0000_0021, 32'hCAFE_F00D, 4'h0, 1'b0, acc);
    go_idle();
    check("nofault_pulse", {31'b0, fault}, 32'h0);
    check("nofault_addr",  fault_addr, 32'h0);
    do_req(1'b1, 1'b0, 32'h0000_0022, 32'h0, 4'h9, 1'b1, acc);
`endif

    // Normal operation after reset.
    do_req(1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'h8, 1'b1, acc);
    go_idle();
    repeat (6) @(negedge clk);
    check("sb_drained", sb.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
